// File: rtl/id_operand_stage_pkg.sv
// Shared constants for the ID operand stage: datapath sizes, the opcode and
// funct encodings that steer operand routing, and the immediate-extension rule.
package id_operand_stage_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;

  // Variable shifts only use the low five bits of the shift-amount register.
  localparam logic [XLEN-1:0] SHAMT_MASK = 32'h0000_001F;

  // Logical immediates are zero-extended, everything else sign-extended.
  function automatic logic [XLEN-1:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
    if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
      return {16'h0000, imm};
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_operand_stage_gpr_file.sv
// gpr_file: 32 x 32 general-purpose register file.
//  CLK/RST          clock, asynchronous active-low reset (clears every register)
//  wb_en/addr/data  synchronous write port; writes to r0 are dropped
//  ra1/rd1, ra2/rd2 two asynchronous read ports; r0 always reads zero
module gpr_file
  import id_operand_stage_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [NREG-1:0][XLEN-1:0] regs;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      regs <= '0;
    else if (wb_en && wb_addr != '0)
      regs[wb_addr] <= wb_data;
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: decode-stage operand generation with a single ID/EX slot.
//  CLK/RST               clock, asynchronous active-low reset
//  in_valid/in_ready     IF -> ID handshake carrying nextPC_in, Ins_in
//  flush                 drop slot contents and anything accepted this cycle
//  wb_en/wb_addr/wb_data WB write port into the GPR file (also bypassed)
//  out_valid/out_ready   ID -> EX handshake
//  nextPC/Ins/Rdata1/Rdata2/Ed32  registered slot payload seen by EX
module id_operand_stage
  import id_operand_stage_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] nextPC_in,
  input  logic [XLEN-1:0] Ins_in,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] nextPC,
  output logic [XLEN-1:0] Ins,
  output logic [XLEN-1:0] Rdata1,
  output logic [XLEN-1:0] Rdata2,
  output logic [XLEN-1:0] Ed32
);

  logic [5:0]      op, funct;
  logic [AW-1:0]   rs, rt;
  logic [XLEN-1:0] rd_rs, rd_rt, byp_rs, byp_rt;

  assign op    = Ins_in[31:26];
  assign rs    = Ins_in[25:21];
  assign rt    = Ins_in[20:16];
  assign funct = Ins_in[5:0];

  gpr_file u_gpr (
    .CLK     (CLK),
    .RST     (RST),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .ra1     (rs),
    .ra2     (rt),
    .rd1     (rd_rs),
    .rd2     (rd_rt)
  );

  // Same-cycle write-back forwarding so a dependent instruction does not wait.
  logic wb_live;
  assign wb_live = wb_en && (wb_addr != '0);
  assign byp_rs  = (wb_live && wb_addr == rs) ? wb_data : rd_rs;
  assign byp_rt  = (wb_live && wb_addr == rt) ? wb_data : rd_rt;

  // Operand routing. Shifts present the shifted value (rt) as operand A.
  // src*/reg2/mask2 remember where each operand came from so a stalled slot
  // can pick up late write-backs.
  logic            shift_imm, shift_var;
  logic [XLEN-1:0] d_r1, d_r2;
  logic [AW-1:0]   d_s1, d_s2;
  logic            d_reg2, d_mask2;

  always_comb begin
    shift_imm = (op == OP_RTYPE) && (funct == F_SLL  || funct == F_SRL  || funct == F_SRA);
    shift_var = (op == OP_RTYPE) && (funct == F_SLLV || funct == F_SRLV || funct == F_SRAV);
    d_r1    = byp_rs;
    d_s1    = rs;
    d_r2    = byp_rt;
    d_s2    = rt;
    d_reg2  = 1'b1;
    d_mask2 = 1'b0;
    if (shift_imm) begin
      d_r1   = byp_rt;
      d_s1   = rt;
      d_r2   = {27'b0, Ins_in[10:6]};
      d_s2   = '0;
      d_reg2 = 1'b0;
    end else if (shift_var) begin
      d_r1    = byp_rt;
      d_s1    = rt;
      d_r2    = byp_rs & SHAMT_MASK;
      d_s2    = rs;
      d_mask2 = 1'b1;
    end
  end

  logic [AW-1:0] src1, src2;
  logic          reg2, mask2;
  logic          accept, stall, hit1, hit2;

  assign in_ready = !out_valid || out_ready || flush;
  assign accept   = in_valid && in_ready;
  assign stall    = out_valid && !out_ready;
  assign hit1     = wb_live && (wb_addr == src1);
  assign hit2     = wb_live && reg2 && (wb_addr == src2);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid <= 1'b0;
      nextPC    <= '0;
      Ins       <= '0;
      Rdata1    <= '0;
      Rdata2    <= '0;
      Ed32      <= '0;
      src1      <= '0;
      src2      <= '0;
      reg2      <= 1'b0;
      mask2     <= 1'b0;
    end else begin
      if (flush)        out_valid <= 1'b0;
      else if (accept)  out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;

      if (accept) begin
        nextPC <= nextPC_in;
        Ins    <= Ins_in;
        Rdata1 <= d_r1;
        Rdata2 <= d_r2;
        Ed32   <= ext_imm(op, Ins_in[15:0]);
        src1   <= d_s1;
        src2   <= d_s2;
        reg2   <= d_reg2;
        mask2  <= d_mask2;
      end else if (stall) begin
        if (hit1) Rdata1 <= wb_data;
        if (hit2) Rdata2 <= mask2 ? (wb_data & SHAMT_MASK) : wb_data;
      end
    end
  end

endmodule
